// File: rtl/fir_output_stage_pkg.sv
// Shared helpers for the FIR output stage: round/saturate arithmetic, output range
// limits and FIFO occupancy sizing.
package fir_output_stage_pkg;

    localparam int CALC_W = 64;

    typedef logic signed [CALC_W-1:0] calc_t;

    typedef struct packed {
        calc_t value;
        logic  sat;
    } round_sat_t;

    function automatic calc_t out_max(input int out_w);
        return (calc_t'(1) <<< (out_w - 1)) - calc_t'(1);
    endfunction

    function automatic calc_t out_min(input int out_w);
        return -(calc_t'(1) <<< (out_w - 1));
    endfunction

    // Count must hold 0..depth inclusive.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Round half toward +inf by adding half an output LSB before the arithmetic shift,
    // then clamp to the signed out_w range. The wide working type cannot overflow.
    function automatic round_sat_t round_sat(input calc_t x, input int frac_shift,
                                             input int out_w);
        round_sat_t res;
        calc_t      r;
        r         = (x + (calc_t'(1) <<< (frac_shift - 1))) >>> frac_shift;
        res.value = r;
        res.sat   = 1'b0;
        if (r > out_max(out_w)) begin
            res.value = out_max(out_w);
            res.sat   = 1'b1;
        end else if (r < out_min(out_w)) begin
            res.value = out_min(out_w);
            res.sat   = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_output_stage_if.sv
// Sample stream between the FIR pipeline, the output stage and the downstream sink.
interface fir_output_stage_if #(
    parameter int IN_WIDTH  = 19,
    parameter int OUT_WIDTH = 8
);
    logic signed [IN_WIDTH-1:0]  in_data;
    logic                        in_valid;
    logic                        upstream_en;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic                        out_valid;
    logic                        out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  upstream_en,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output upstream_en,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/fir_output_stage_fifo.sv
// Synchronous output FIFO; head is registered storage (no fall-through) and reads 0
// while empty.
module fir_output_stage_fifo
    import fir_output_stage_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CNT_W = fifo_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO only lands when the same cycle frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fir_output_stage.sv
// FIR output stage: round/saturate, decimate, stage register and output FIFO, with
// upstream_en throttling the filter so sink backpressure never loses a sample.
module fir_output_stage
    import fir_output_stage_pkg::*;
#(
    parameter int IN_WIDTH   = 19,
    parameter int OUT_WIDTH  = 8,
    parameter int FRAC_SHIFT = 3,
    parameter int DECIM      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    fir_output_stage_if.slave   io,
    input  logic                clear_flags,
    output logic                sat_flag,
    output logic                drop_flag
);
    localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int CNT_W = fifo_cnt_w(FIFO_DEPTH);

    logic [PH_W-1:0]              phase;
    logic                         keep_p0;
    round_sat_t                   rs_p0;
    logic                         unused_rs_hi;
    logic signed [OUT_WIDTH-1:0]  data_p1;
    logic                         vld_p1;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         fifo_drop;
    logic [CNT_W-1:0]             fifo_count;
    logic [OUT_WIDTH-1:0]         fifo_head;

    // ---- p0: decimation phase and round/saturate of the incoming sample ----
    assign keep_p0      = io.in_valid && (phase == '0);
    assign rs_p0        = round_sat(calc_t'(io.in_data), FRAC_SHIFT, OUT_WIDTH);
    assign unused_rs_hi = ^rs_p0.value[CALC_W-1:OUT_WIDTH];

    // Phase follows every valid input, independent of FIFO state, so stalls never
    // shift the decimation alignment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (io.in_valid) begin
            phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + 1'b1;
        end
    end

    // ---- p1: stage register feeding the FIFO ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= keep_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (keep_p0) data_p1 <= rs_p0.value[OUT_WIDTH-1:0];
    end

    // ---- p2: output FIFO ----
    fir_output_stage_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vld_p1),
        .push_data (data_p1),
        .pop       (io.out_ready),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign fifo_drop    = vld_p1 && fifo_full && !io.out_ready;
    assign io.out_data  = fifo_head;
    assign io.out_valid = !fifo_empty;

    // Leave room for the two samples already in flight (FIR output reg + stage reg).
    assign io.upstream_en = (fifo_count <= CNT_W'(FIFO_DEPTH - 3));

    // A set event in the same cycle as clear_flags wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag  <= 1'b0;
            drop_flag <= 1'b0;
        end else begin
            sat_flag  <= (keep_p0 && rs_p0.sat) || (sat_flag && !clear_flags);
            drop_flag <= fifo_drop || (drop_flag && !clear_flags);
        end
    end

endmodule

// File: tb/tb_fir_output_stage.sv
// Bench for fir_output_stage: a DECIM=1 instance for rounding, saturation, backpressure
// and FIFO corner cases, and a DECIM=2 instance for decimation and phase reset.
`timescale 1ns/1ps
module tb_fir_output_stage;

    localparam int IN_W  = 19;
    localparam int OUT_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr1, clr2;
    logic sat1, drop1, sat2, drop2;

    int n_cmp = 0;
    int n_bad = 0;
    int q1[$];
    int q2[$];
    int ph2 = 0;

    always #5 clk = ~clk;

    fir_output_stage_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) io1 ();
    fir_output_stage_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) io2 ();

    fir_output_stage #(
        .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .FRAC_SHIFT(3), .DECIM(1), .FIFO_DEPTH(4)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .io(io1), .clear_flags(clr1),
        .sat_flag(sat1), .drop_flag(drop1)
    );

    fir_output_stage #(
        .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .FRAC_SHIFT(3), .DECIM(2), .FIFO_DEPTH(4)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .io(io2), .clear_flags(clr2),
        .sat_flag(sat2), .drop_flag(drop2)
    );

    typedef struct {
        int din;
        int dout;
        bit sat;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: round half up at 3 fractional bits, clamp to signed 8 bits.
    function automatic int exp_of(input int v);
        int r;
        r = (v + 4) >>> 3;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    task automatic send1(input int v, input int e, input bit expect_out);
        io1.in_data  = IN_W'(v);
        io1.in_valid = 1'b1;
        if (expect_out) q1.push_back(e);
        tick();
        io1.in_valid = 1'b0;
    endtask

    // Leaves in_valid asserted so back-to-back samples can be streamed.
    task automatic send2(input int v);
        io2.in_data  = IN_W'(v);
        io2.in_valid = 1'b1;
        if (ph2 == 0) q2.push_back(exp_of(v));
        ph2 = (ph2 + 1) % 2;
        tick();
    endtask

    // Scoreboard: every accepted output is matched against the oldest expected value.
    always @(negedge clk) begin
        if (rst_n && io1.out_valid && io1.out_ready) begin
            if (q1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut1 extra output: got %0d, expected no output", io1.out_data);
            end else begin
                chk("dut1 out_data", io1.out_data, q1.pop_front());
            end
        end
        if (rst_n && io2.out_valid && io2.out_ready) begin
            if (q2.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut2 extra output: got %0d, expected no output", io2.out_data);
            end else begin
                chk("dut2 out_data", io2.out_data, q2.pop_front());
            end
        end
    end

    initial begin
        bit en_q, en_now;
        int issued;

        tbl[0]  = '{din: 12,      dout: 2,    sat: 0};
        tbl[1]  = '{din: -12,     dout: -1,   sat: 0};
        tbl[2]  = '{din: 11,      dout: 1,    sat: 0};
        tbl[3]  = '{din: 4,       dout: 1,    sat: 0};
        tbl[4]  = '{din: -5,      dout: -1,   sat: 0};
        tbl[5]  = '{din: 1019,    dout: 127,  sat: 0};
        tbl[6]  = '{din: 1020,    dout: 127,  sat: 1};
        tbl[7]  = '{din: -1028,   dout: -128, sat: 0};
        tbl[8]  = '{din: -1029,   dout: -128, sat: 1};
        tbl[9]  = '{din: 2000,    dout: 127,  sat: 1};
        tbl[10] = '{din: 262143,  dout: 127,  sat: 1};
        tbl[11] = '{din: -2000,   dout: -128, sat: 1};

        io1.in_data = '0; io1.in_valid = 1'b0; io1.out_ready = 1'b1;
        io2.in_data = '0; io2.in_valid = 1'b0; io2.out_ready = 1'b1;
        clr1 = 1'b0; clr2 = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("reset out_valid", io1.out_valid, 0);
        chk("reset out_data", io1.out_data, 0);
        chk("reset sat_flag", sat1, 0);
        chk("reset drop_flag", drop1, 0);
        rst_n = 1'b1;
        tick();
        chk("upstream_en after reset", io1.upstream_en, 1);

        // Rounding and saturation vectors
        for (int i = 0; i < 12; i++) begin
            clr1 = 1'b1; tick(); clr1 = 1'b0;
            send1(tbl[i].din, tbl[i].dout, 1'b1);
            tick(); tick();
            chk($sformatf("sat_flag vec%0d", i), sat1, tbl[i].sat);
        end
        clr1 = 1'b1; tick(); clr1 = 1'b0;
        chk("sat_flag cleared", sat1, 0);

        // Set beats clear in the same cycle
        clr1 = 1'b1;
        send1(2000, 127, 1'b1);
        clr1 = 1'b0;
        chk("sat_flag set wins over clear", sat1, 1);
        tick(); tick();
        clr1 = 1'b1; tick(); clr1 = 1'b0;

        // Decimation by 2 with latency check
        send2(8);
        chk("dut2 out_valid one edge after input", io2.out_valid, 0);
        send2(16);
        chk("dut2 out_valid two edges after input", io2.out_valid, 1);
        chk("dut2 first out_data", io2.out_data, 1);
        send2(24);
        send2(32);
        io2.in_valid = 1'b0;
        repeat (4) tick();
        chk("dut2 scoreboard drained", q2.size(), 0);
        chk("dut2 out_valid idle", io2.out_valid, 0);

        // Backpressure: in_valid follows upstream_en delayed one cycle
        io1.out_ready = 1'b0;
        en_q = 1'b1;
        issued = 0;
        for (int c = 0; c < 10; c++) begin
            en_now = io1.upstream_en;
            if (en_q) begin
                io1.in_data  = IN_W'(80 + 8 * issued);
                io1.in_valid = 1'b1;
                q1.push_back(exp_of(80 + 8 * issued));
                issued++;
            end else begin
                io1.in_valid = 1'b0;
            end
            tick();
            en_q = en_now;
        end
        io1.in_valid = 1'b0;
        chk("samples issued under backpressure", issued, 4);
        chk("upstream_en with full FIFO", io1.upstream_en, 0);
        chk("drop_flag under backpressure", drop1, 0);
        chk("head under backpressure", io1.out_data, 10);
        io1.out_ready = 1'b1;
        repeat (6) tick();
        chk("backpressure drain", q1.size(), 0);
        chk("upstream_en after drain", io1.upstream_en, 1);
        chk("out_valid after drain", io1.out_valid, 0);

        // Full FIFO: push with simultaneous pop, then push without pop
        io1.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) send1(200 + 8 * k, 25 + k, 1'b1);
        io1.out_ready = 1'b1;
        tick();
        io1.out_ready = 1'b0;
        chk("drop_flag after full push+pop", drop1, 0);
        chk("head after full push+pop", io1.out_data, 26);
        send1(240, 30, 1'b0);
        tick();
        chk("drop_flag after full push", drop1, 1);
        chk("head unchanged after drop", io1.out_data, 26);
        clr1 = 1'b1; tick(); clr1 = 1'b0;
        chk("drop_flag cleared", drop1, 0);
        io1.out_ready = 1'b1;
        repeat (6) tick();
        chk("full FIFO drain", q1.size(), 0);

        // Reset mid-stream
        send2(8);
        io2.in_valid = 1'b0;
        io1.out_ready = 1'b0;
        send1(2000, 127, 1'b1);
        send1(16, 2, 1'b1);
        send1(24, 3, 1'b1);
        tick(); tick();
        chk("pre-reset out_valid", io1.out_valid, 1);
        chk("pre-reset sat_flag", sat1, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset mid-stream out_valid", io1.out_valid, 0);
        chk("reset mid-stream sat_flag", sat1, 0);
        chk("reset mid-stream upstream_en", io1.upstream_en, 1);
        q1.delete();
        ph2 = 0;
        tick(); tick();
        rst_n = 1'b1;
        io1.out_ready = 1'b1;
        send2(40);
        io2.in_valid = 1'b0;
        send1(12, 2, 1'b1);
        repeat (4) tick();
        chk("dut2 first sample after reset kept", q2.size(), 0);
        chk("dut1 output after reset", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
